// File: rtl/uart_tx_engine.sv
// UART transmitter: a DEPTH-entry byte FIFO feeding a start/data/parity/stop serializer.
// Divisor and frame format are captured as each frame starts, so cfg changes only affect later frames.
module uart_tx_engine #(
    parameter int DEPTH = 8,
    parameter int DIV_W = 16,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_en,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [1:0]       cfg_nbits,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_nstop,
    input  logic [CW-1:0]    cfg_txwm,
    input  logic             enq_valid,
    input  logic [7:0]       enq_data,
    output logic             enq_ready,
    input  logic             flush,
    output logic             txd,
    output logic [CW-1:0]    count,
    output logic             busy,
    output logic             ip_txwm
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state_q, state_d;

    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic             stop_q, stop_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [1:0]       nbits_q, nbits_d, parity_q, parity_d;
    logic             nstop_q, nstop_d;
    logic             txd_q, txd_d, busy_q, busy_d;
    logic             push, pop, start_ok, tick;
    logic [7:0]       head, head_mask;

    assign enq_ready = (count_q != FULL) && !flush;
    assign push      = enq_valid && enq_ready;
    assign start_ok  = cfg_en && (count_q != '0) && !flush;
    assign tick      = (cnt_q == '0);
    assign head      = mem_q[rd_ptr_q];
    // Bits above the configured width never reach the line, so keep them out of parity.
    assign head_mask = head & (8'hFF >> (2'd3 - cfg_nbits));
    assign count_d   = flush ? '0 : count_q + CW'(push) - CW'(pop);

    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= enq_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            nbits_q  <= '0;
            parity_q <= '0;
            nstop_q  <= 1'b0;
            txd_q    <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            nbits_q  <= nbits_d;
            parity_q <= parity_d;
            nstop_q  <= nstop_d;
            txd_q    <= txd_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
        par_d    = par_q;
        nbits_d  = nbits_q;
        parity_d = parity_q;
        nstop_d  = nstop_q;
        pop      = 1'b0;
        if (state_q != IDLE) cnt_d = tick ? div_q : cnt_q - 1'b1;
        case (state_q)
            IDLE:   pop = start_ok;
            START:  if (tick) begin
                        state_d = DATA;
                        bit_d   = '0;
                    end
            DATA:   if (tick) begin
                        if (bit_q == {1'b0, nbits_q} + 3'd4) begin
                            state_d = (parity_q == 2'd1 || parity_q == 2'd2) ? PARITY : STOP;
                        end else begin
                            bit_d   = bit_q + 1'b1;
                            shift_d = shift_q >> 1;
                        end
                    end
            PARITY: if (tick) state_d = STOP;
            STOP:   if (tick) begin
                        if (nstop_q && !stop_q) begin
                            stop_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                            pop     = start_ok;
                        end
                    end
            default: state_d = IDLE;
        endcase
        // Popping doubles as the frame start: capture byte and format together.
        if (pop) begin
            state_d  = START;
            cnt_d    = cfg_div;
            div_d    = cfg_div;
            nbits_d  = cfg_nbits;
            parity_d = cfg_parity;
            nstop_d  = cfg_nstop;
            stop_d   = 1'b0;
            shift_d  = head;
            par_d    = (^head_mask) ^ (cfg_parity == 2'd2);
        end
    end

    always_comb begin
        busy_d = (state_d != IDLE);
        case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_d[0];
            PARITY:  txd_d = par_d;
            default: txd_d = 1'b1;
        endcase
    end

    assign txd     = txd_q;
    assign busy    = busy_q;
    assign count   = count_q;
    assign ip_txwm = (count_q < cfg_txwm);
endmodule
